// File: rtl/control_botones_ajuste_pkg.sv
// control_botones_ajuste_pkg
// Shared definitions for the time-setting button front-end:
//   - field codes driven on contadoresH (0 = no field being edited)
//   - encoding of the hold-to-repeat FSM states
//   - ancho(): counter width helper that never returns 0
package control_botones_ajuste_pkg;

    localparam logic [3:0] CAMPO_NINGUNO = 4'd0;
    localparam logic [3:0] CAMPO_SS      = 4'd1;
    localparam logic [3:0] CAMPO_MM      = 4'd2;
    localparam logic [3:0] CAMPO_HH      = 4'd3;
    localparam logic [3:0] CAMPO_DIA     = 4'd4;
    localparam logic [3:0] CAMPO_MES     = 4'd5;
    localparam logic [3:0] CAMPO_ANO     = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_LOCK   = 2'd3
    } estado_t;

    // Width of a counter that must hold values 0..n-1; a degenerate n of 1
    // still gets a one-bit counter.
    function automatic int ancho(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/control_botones_ajuste_antirrebote.sv
// control_botones_ajuste_antirrebote
// 2-FF synchronizer followed by a debouncer for one raw push-button level.
// The stable level flips only after the synchronized input has disagreed
// with it for DEBOUNCE_CYC consecutive cycles; any agreeing sample restarts
// the count.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   entrada     : raw asynchronous button level (1 = pressed)
//   estable     : debounced level (registered)
//   pulsacion   : one-cycle pulse on each 0->1 change of estable (registered)
module control_botones_ajuste_antirrebote
    import control_botones_ajuste_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic entrada,
    output logic estable,
    output logic pulsacion
);

    localparam int             CW     = ancho(DEBOUNCE_CYC);
    localparam logic [CW-1:0]  ULTIMO = CW'(DEBOUNCE_CYC - 1);

    logic          sinc1;
    logic          sinc2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sinc1     <= 1'b0;
            sinc2     <= 1'b0;
            estable   <= 1'b0;
            pulsacion <= 1'b0;
            cnt       <= '0;
        end else begin
            sinc1     <= entrada;
            sinc2     <= sinc1;
            pulsacion <= 1'b0;
            if (sinc2 == estable) begin
                cnt <= '0;
            end else if (cnt == ULTIMO) begin
                // DEBOUNCE_CYC-th consecutive disagreeing sample: accept it.
                estable   <= sinc2;
                pulsacion <= sinc2;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/control_botones_ajuste.sv
// control_botones_ajuste
// Button front-end for the time-setting path. Debounces five buttons, keeps
// the register of the field being edited and generates Arriba/Abajo pulses
// with hold-to-repeat.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   btn_up/down/left/right/cfg : raw button levels (1 = pressed)
//   Arriba, Abajo         : one-cycle increment/decrement pulses (registered)
//   contadoresH           : active field code, 0..N_FIELDS (registered)
//   modo_config           : 1 while contadoresH != 0 (registered)
//   estado                : current repeat FSM state, for observation
module control_botones_ajuste
    import control_botones_ajuste_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = 1_000_000,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 13_000_000,
    parameter int N_FIELDS      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_cfg,
    output logic       Arriba,
    output logic       Abajo,
    output logic [3:0] contadoresH,
    output logic       modo_config,
    output estado_t    estado
);

    localparam logic [3:0] N_CAMPOS = 4'(N_FIELDS);
    localparam int CNT_TOPE = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW = ancho(CNT_TOPE);
    localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

    logic stable_up, stable_down, stable_left, stable_right, stable_cfg;
    logic press_up, press_down, press_left, press_right, press_cfg;

    control_botones_ajuste_antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ar_up (
        .clk(clk), .reset(reset), .entrada(btn_up), .estable(stable_up), .pulsacion(press_up));
    control_botones_ajuste_antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ar_down (
        .clk(clk), .reset(reset), .entrada(btn_down), .estable(stable_down), .pulsacion(press_down));
    control_botones_ajuste_antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ar_left (
        .clk(clk), .reset(reset), .entrada(btn_left), .estable(stable_left), .pulsacion(press_left));
    control_botones_ajuste_antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ar_right (
        .clk(clk), .reset(reset), .entrada(btn_right), .estable(stable_right), .pulsacion(press_right));
    control_botones_ajuste_antirrebote #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ar_cfg (
        .clk(clk), .reset(reset), .entrada(btn_cfg), .estable(stable_cfg), .pulsacion(press_cfg));

    // Up/down act on levels, left/right/cfg on press events.
    logic unused_ok;
    assign unused_ok = ^{press_up, press_down, stable_left, stable_right, stable_cfg};

    // Next field value. A cfg press takes priority over arrows landing in
    // the same cycle; simultaneous left+right cancel out.
    logic [3:0] field_next;
    always_comb begin
        field_next = contadoresH;
        if (press_cfg) begin
            field_next = (contadoresH == CAMPO_NINGUNO) ? CAMPO_SS : CAMPO_NINGUNO;
        end else if (contadoresH != CAMPO_NINGUNO && (press_right ^ press_left)) begin
            if (press_right)
                field_next = (contadoresH >= N_CAMPOS) ? CAMPO_SS : contadoresH + 4'd1;
            else
                field_next = (contadoresH <= CAMPO_SS) ? N_CAMPOS : contadoresH - 4'd1;
        end
    end

    logic          dir_up;      // direction latched on entry to DELAY
    logic [CW-1:0] cnt;
    logic          ambos;
    logic          sostenido;
    logic          cambio;
    logic          activo;
    logic [CW-1:0] ultimo;

    assign ambos     = stable_up & stable_down;
    assign sostenido = dir_up ? stable_up : stable_down;
    assign cambio    = (field_next != contadoresH);
    assign activo    = (contadoresH != CAMPO_NINGUNO);
    assign ultimo    = (estado == ST_DELAY) ? DELAY_LAST : PERIOD_LAST;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado      <= ST_IDLE;
            cnt         <= '0;
            dir_up      <= 1'b0;
            Arriba      <= 1'b0;
            Abajo       <= 1'b0;
            contadoresH <= CAMPO_NINGUNO;
            modo_config <= 1'b0;
        end else begin
            Arriba      <= 1'b0;
            Abajo       <= 1'b0;
            contadoresH <= field_next;
            modo_config <= (field_next != CAMPO_NINGUNO);
            case (estado)
                ST_IDLE: begin
                    if (ambos) begin
                        estado <= ST_LOCK;
                    end else if (stable_up ^ stable_down) begin
                        estado <= ST_DELAY;
                        cnt    <= '0;
                        dir_up <= stable_up;
                        Arriba <= activo & stable_up;
                        Abajo  <= activo & stable_down;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (ambos || cambio) begin
                        estado <= ST_LOCK;
                    end else if (!sostenido) begin
                        estado <= ST_IDLE;
                    end else if (cnt == ultimo) begin
                        estado <= ST_REPEAT;
                        cnt    <= '0;
                        Arriba <= activo & dir_up;
                        Abajo  <= activo & ~dir_up;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_LOCK: begin
                    // Leave only once neither up nor down is held.
                    if (!stable_up && !stable_down)
                        estado <= ST_IDLE;
                end
                default: estado <= ST_IDLE;
            endcase
        end
    end

endmodule
